// File: rtl/dmem_arbiter.sv
// Two-master arbiter for one single-port sync-read DMEM SRAM (M0 = core data, M1 = DMA/debug).
// Latency: grant is combinational (0 cycles); read data and RVALID return 1 cycle after the grant.
// Backpressure: a master holds REQ until GNT; a lock owner blocks the other master, who then waits.
// Optional feature: define DMEM_ARB_RR_EN for round-robin contention; otherwise M0 has fixed priority.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          M0_REQ,
  input  logic          M0_WEN,
  input  logic          M0_LOCK,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [DW-1:0] M0_WDATA,
  output logic          M0_GNT,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_RVALID,
  input  logic          M1_REQ,
  input  logic          M1_WEN,
  input  logic          M1_LOCK,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M1_WDATA,
  output logic          M1_GNT,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_RVALID,
  output logic [AW-1:0] MADDR,
  output logic          MWEN,
  output logic [DW-1:0] MWDATA,
  input  logic [DW-1:0] MRDATA
);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lock_t;

  lock_t lock_own;
  logic  rd_pend;
  logic  rd_own;
`ifdef DMEM_ARB_RR_EN
  logic  last_win;
`endif

  logic  elig0;
  logic  elig1;
  logic  gnt;
  logic  win;
  logic  win_wen;
  logic  win_lock;
  lock_t win_tag;

  // Winner selection: lock ownership filters eligibility, then contention is resolved.
  always_comb begin
    elig0 = M0_REQ && (lock_own != LOCK_M1) && !RST;
    elig1 = M1_REQ && (lock_own != LOCK_M0) && !RST;
`ifdef DMEM_ARB_RR_EN
    // On contention the master that did not win last time gets the slot.
    win   = elig1 && (!elig0 || !last_win);
`else
    // On contention M0 always wins; M1 may starve, which is tolerated for debug traffic.
    win   = elig1 && !elig0;
`endif
    gnt      = elig0 || elig1;
    win_wen  = win ? M1_WEN  : M0_WEN;
    win_lock = win ? M1_LOCK : M0_LOCK;
    win_tag  = win ? LOCK_M1 : LOCK_M0;
  end

  // Grant outputs and SRAM request mux; everything is zero when nobody is granted.
  always_comb begin
    M0_GNT = gnt && !win;
    M1_GNT = gnt && win;
    MADDR  = '0;
    MWEN   = 1'b0;
    MWDATA = '0;
    if (gnt) begin
      MADDR  = win ? M1_ADDR  : M0_ADDR;
      MWEN   = win_wen;
      MWDATA = win ? M1_WDATA : M0_WDATA;
    end
  end

  // Arbitration state: lock owner, outstanding read tracking and round-robin history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_own <= LOCK_NONE;
      rd_pend  <= 1'b0;
      rd_own   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_win <= 1'b1;
`endif
    end else begin
      rd_pend <= gnt && !win_wen;
      if (gnt) begin
        rd_own <= win;
`ifdef DMEM_ARB_RR_EN
        last_win <= win;
`endif
        if (win_lock) begin
          lock_own <= win_tag;
        end else if (lock_own == win_tag) begin
          lock_own <= LOCK_NONE;
        end
      end else begin
        // An idle owner that drops LOCK gives up ownership without issuing an access.
        if ((lock_own == LOCK_M0) && !M0_REQ && !M0_LOCK) begin
          lock_own <= LOCK_NONE;
        end
        if ((lock_own == LOCK_M1) && !M1_REQ && !M1_LOCK) begin
          lock_own <= LOCK_NONE;
        end
      end
    end
  end

  // Read return: steer SRAM data to the master that issued the read one cycle ago.
  always_comb begin
    M0_RVALID = rd_pend && !rd_own;
    M1_RVALID = rd_pend && rd_own;
    M0_RDATA  = M0_RVALID ? MRDATA : '0;
    M1_RDATA  = M1_RVALID ? MRDATA : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural sync-read SRAM.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expectations adapt to the DMEM_ARB_RR_EN build option.
module tb_dmem_arbiter;

  logic        CLK;
  logic        RST;
  logic        M0_REQ, M0_WEN, M0_LOCK;
  logic [31:0] M0_ADDR, M0_WDATA;
  logic        M0_GNT, M0_RVALID;
  logic [31:0] M0_RDATA;
  logic        M1_REQ, M1_WEN, M1_LOCK;
  logic [31:0] M1_ADDR, M1_WDATA;
  logic        M1_GNT, M1_RVALID;
  logic [31:0] M1_RDATA;
  logic [31:0] MADDR, MWDATA, MRDATA;
  logic        MWEN;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .M0_REQ(M0_REQ), .M0_WEN(M0_WEN), .M0_LOCK(M0_LOCK), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_GNT(M0_GNT), .M0_RDATA(M0_RDATA), .M0_RVALID(M0_RVALID),
    .M1_REQ(M1_REQ), .M1_WEN(M1_WEN), .M1_LOCK(M1_LOCK), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_GNT(M1_GNT), .M1_RDATA(M1_RDATA), .M1_RVALID(M1_RVALID),
    .MADDR(MADDR), .MWEN(MWEN), .MWDATA(MWDATA), .MRDATA(MRDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port synchronous-read SRAM, word-indexed by the low address bits.
  always @(posedge CLK) begin
    if (MWEN) mem[MADDR[7:0]] <= MWDATA;
    MRDATA <= mem[MADDR[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    M0_REQ = 0; M0_WEN = 0; M0_LOCK = 0; M0_ADDR = '0; M0_WDATA = '0;
    M1_REQ = 0; M1_WEN = 0; M1_LOCK = 0; M1_ADDR = '0; M1_WDATA = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  logic exp1;
  logic prev1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'h11112222;
    MRDATA = '0;

    // Reset state, with a write request pending on M0 that must be blocked.
    idle_inputs();
    RST = 1;
    M0_REQ = 1; M0_WEN = 1; M0_ADDR = 32'h44; M0_WDATA = 32'hCAFEF00D;
    next_cycle();
    next_cycle();
    chk1("rst_m0_gnt", M0_GNT, 1'b0);
    chk1("rst_mwen", MWEN, 1'b0);
    chk1("rst_m0_rv", M0_RVALID, 1'b0);
    chk1("rst_m1_rv", M1_RVALID, 1'b0);
    chk("rst_m0_rdata", M0_RDATA, 32'h0);
    chk("rst_m1_rdata", M1_RDATA, 32'h0);
    RST = 0;
    idle_inputs();
    next_cycle();

    // Single M0 read of preloaded 0x10.
    M0_REQ = 1; M0_ADDR = 32'h10;
    @(negedge CLK);
    chk1("rd_m0_gnt", M0_GNT, 1'b1);
    chk1("rd_m1_gnt", M1_GNT, 1'b0);
    chk("rd_maddr", MADDR, 32'h10);
    chk1("rd_mwen", MWEN, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk1("rd_m0_rv", M0_RVALID, 1'b1);
    chk("rd_m0_rdata", M0_RDATA, 32'hDEADBEEF);
    chk1("rd_m1_rv", M1_RVALID, 1'b0);
    chk("rd_m1_rdata", M1_RDATA, 32'h0);
    next_cycle();

    // M1 writes 0x20, M0 reads it back in the very next cycle.
    M1_REQ = 1; M1_WEN = 1; M1_ADDR = 32'h20; M1_WDATA = 32'h5A5A5A5A;
    @(negedge CLK);
    chk1("wr_m1_gnt", M1_GNT, 1'b1);
    chk1("wr_mwen", MWEN, 1'b1);
    chk("wr_mwdata", MWDATA, 32'h5A5A5A5A);
    next_cycle();
    idle_inputs();
    M0_REQ = 1; M0_ADDR = 32'h20;
    @(negedge CLK);
    chk1("wr_rd_m0_gnt", M0_GNT, 1'b1);
    chk1("wr_no_rv", M1_RVALID, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk1("wr_rd_m0_rv", M0_RVALID, 1'b1);
    chk("wr_rd_m0_rdata", M0_RDATA, 32'h5A5A5A5A);
    next_cycle();

    // Continuous contention from a fresh reset.
    RST = 1;
    next_cycle();
    RST = 0;
    M0_REQ = 1; M0_ADDR = 32'h10;
    M1_REQ = 1; M1_ADDR = 32'h20;
    prev1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      @(negedge CLK);
      chk1("cont_m0_gnt", M0_GNT, !exp1);
      chk1("cont_m1_gnt", M1_GNT, exp1);
      if (i > 0) begin
        chk1("cont_m1_rv", M1_RVALID, prev1);
        chk("cont_m1_rdata", M1_RDATA, prev1 ? 32'h5A5A5A5A : 32'h0);
        chk("cont_m0_rdata", M0_RDATA, prev1 ? 32'h0 : 32'hDEADBEEF);
      end
      prev1 = exp1;
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Locked read-modify-write on 0x30 while M1 keeps requesting.
    M0_REQ = 1; M0_ADDR = 32'h30; M0_LOCK = 1;
    M1_REQ = 1; M1_ADDR = 32'h10;
    @(negedge CLK);
    chk1("lk_m0_gnt", M0_GNT, 1'b1);
    chk1("lk_m1_gnt", M1_GNT, 1'b0);
    next_cycle();
    M0_REQ = 0;
    @(negedge CLK);
    chk1("lk_idle1_m1_gnt", M1_GNT, 1'b0);
    chk1("lk_m0_rv", M0_RVALID, 1'b1);
    chk("lk_m0_rdata", M0_RDATA, 32'h11112222);
    next_cycle();
    @(negedge CLK);
    chk1("lk_idle2_m1_gnt", M1_GNT, 1'b0);
    chk1("lk_idle2_m0_gnt", M0_GNT, 1'b0);
    next_cycle();
    M0_REQ = 1; M0_WEN = 1; M0_LOCK = 0; M0_WDATA = 32'h33334444;
    @(negedge CLK);
    chk1("lk_wr_m0_gnt", M0_GNT, 1'b1);
    chk1("lk_wr_m1_gnt", M1_GNT, 1'b0);
    chk1("lk_wr_mwen", MWEN, 1'b1);
    next_cycle();
    M0_REQ = 0; M0_WEN = 0;
    @(negedge CLK);
    chk1("lk_after_m1_gnt", M1_GNT, 1'b1);
    chk("lk_after_maddr", MADDR, 32'h10);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk1("lk_after_m1_rv", M1_RVALID, 1'b1);
    chk("lk_after_m1_rdata", M1_RDATA, 32'hDEADBEEF);
    next_cycle();

    // Reset right after a locked M1 read grant.
    M1_REQ = 1; M1_ADDR = 32'h10; M1_LOCK = 1;
    @(negedge CLK);
    chk1("rr_m1_gnt", M1_GNT, 1'b1);
    next_cycle();
    RST = 1;
    idle_inputs();
    @(negedge CLK);
    chk1("rr_m1_rv", M1_RVALID, 1'b0);
    chk("rr_m1_rdata", M1_RDATA, 32'h0);
    chk("rr_lock_own", 32'(dut.lock_own), 32'h0);
    next_cycle();
    RST = 0;
    @(negedge CLK);
    chk1("rr_m1_rv_post", M1_RVALID, 1'b0);
    next_cycle();
    M0_REQ = 1; M0_ADDR = 32'h20;
    M1_REQ = 1; M1_ADDR = 32'h10;
    @(negedge CLK);
    chk1("rr_cont_m0_gnt", M0_GNT, 1'b1);
    chk1("rr_cont_m1_gnt", M1_GNT, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk1("rr_cont_m0_rv", M0_RVALID, 1'b1);
    chk("rr_cont_m0_rdata", M0_RDATA, 32'h5A5A5A5A);
    next_cycle();

    // Idle cycles with write-looking but unrequested inputs: no SRAM activity.
    M0_WEN = 1; M0_ADDR = 32'h10; M0_WDATA = 32'hFFFFFFFF;
    M1_WEN = 1; M1_ADDR = 32'h20; M1_WDATA = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk1("idle_mwen", MWEN, 1'b0);
      chk("idle_maddr", MADDR, 32'h0);
      chk("idle_mwdata", MWDATA, 32'h0);
      chk1("idle_gnt", M0_GNT | M1_GNT, 1'b0);
      next_cycle();
    end

    // Back-to-back read-back from both masters.
    idle_inputs();
    M0_REQ = 1; M0_ADDR = 32'h10;
    @(negedge CLK);
    chk1("rb0_m0_gnt", M0_GNT, 1'b1);
    next_cycle();
    idle_inputs();
    M1_REQ = 1; M1_ADDR = 32'h20;
    @(negedge CLK);
    chk1("rb1_m1_gnt", M1_GNT, 1'b1);
    chk("rb1_m0_rdata", M0_RDATA, 32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    M0_REQ = 1; M0_ADDR = 32'h30;
    @(negedge CLK);
    chk1("rb2_m0_gnt", M0_GNT, 1'b1);
    chk1("rb2_m1_rv", M1_RVALID, 1'b1);
    chk("rb2_m1_rdata", M1_RDATA, 32'h5A5A5A5A);
    chk1("rb2_m0_rv", M0_RVALID, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    chk1("rb3_m0_rv", M0_RVALID, 1'b1);
    chk("rb3_m0_rdata", M0_RDATA, 32'h33334444);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares one single-port synchronous-read data SRAM between the processor core's data port (master 0) and a DMA/debug loader port (master 1). It sits between the CORE data interface and the DMEM SRAM instance in the ARMv6 top level. It grants at most one access per clock, routes the one-cycle-late read data back to the master that issued the read, and supports a lock for atomic read-modify-write sequences.

## Interface
- AW, 32: address width, passed through unmodified; word slicing is done at the SRAM instance.
- DW, 32: data width.
- CLK  in  1  clock; the SRAM is clocked by the same clock.
- RST  in  1  asynchronous, active-high reset.
- M0_REQ, M1_REQ  in  1  access request, held until granted.
- M0_WEN, M1_WEN  in  1  0 = read, 1 = write.
- M0_LOCK, M1_LOCK  in  1  keep ownership after this access.
- M0_ADDR, M1_ADDR  in  AW  access address.
- M0_WDATA, M1_WDATA  in  DW  write data.
- M0_GNT, M1_GNT  out  1  access accepted this cycle; combinational.
- M0_RDATA, M1_RDATA  out  DW  read data.
- M0_RVALID, M1_RVALID  out  1  read data valid; registered.
- MADDR  out  AW  SRAM address.
- MWEN  out  1  SRAM write enable.
- MWDATA  out  DW  SRAM write data.
- MRDATA  in  DW  SRAM read data; valid one cycle after the read address is applied.

## Operation
- State registers:
  - last_win (1b): last granted master.
  - lock_own (2b): NONE, M0 or M1.
  - rd_pend (1b) and rd_own (1b): an outstanding read and which master issued it.
- Winner selection, in priority order:
  - If lock_own = Mx, only Mx can be granted. The other master's REQ is ignored and waits.
  - Otherwise, if only one master requests, it wins.
  - If both request, the master that is not last_win wins (round robin; see Configuration).
- On a grant:
  - GNT is high for the winner only.
  - MADDR, MWEN and MWDATA are muxed from the winner in the same cycle.
  - last_win is updated to the winner at the next clock edge.
- With no grant: MWEN=0, MADDR=0, MWDATA=0. No spurious writes are allowed.
- Lock:
  - A granted access with LOCK=1 sets lock_own to that master.
  - A granted access with LOCK=0 by the owner clears lock_own to NONE.
  - The owner may idle (REQ=0) while locked; ownership is kept.
  - If the owner drops LOCK while REQ=0, lock_own clears at the next edge.
- Read return:
  - A granted read sets rd_pend=1 and rd_own=winner.
  - On the next cycle, RVALID of rd_own pulses for one cycle, and that master's RDATA is taken from MRDATA.
  - Reads are fully pipelined: back-to-back reads, from either master, can be granted every cycle.
- RDATA of the non-owning master is 0.
- A write produces no RVALID.

## Timing
- Grant: 0 cycles, combinational from REQ and state.
- Read latency: RVALID and RDATA are valid exactly 1 cycle after the GNT cycle.
- Write: takes effect at the clock edge that closes the GNT cycle.
- Throughput: one access per cycle. With both masters requesting continuously and no lock, grants strictly alternate.
- Reset values:
  - last_win=M1, so M0 wins the first contention.
  - lock_own=NONE, rd_pend=0.
  - M0_RVALID=M1_RVALID=0, RDATA=0.
  - GNT=0 and MWEN=0 while RST is high.
- Reset during an access:
  - An outstanding read is dropped and no RVALID is produced.
  - Any lock is released.
  - The state is the same as after power-up reset.
- Simultaneous events:
  - A lock owner's LOCK=0 access and the other master's REQ in the same cycle: the owner is granted; the other master is eligible from the next cycle.
  - A read return and a new grant in the same cycle are independent.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration as described, using last_win.
- DMEM_ARB_RR_EN undefined: fixed priority, M0 always wins contention.
  - last_win is not implemented.
  - Lock behaviour is unchanged.
  - M1 can starve, which is acceptable for debug-only use.

## Test plan
- Reset, then M0 reads addr 0x10 with the SRAM preloaded with 0xDEADBEEF:
  - M0_GNT is high in cycle 0.
  - M0_RVALID=1 and M0_RDATA=0xDEADBEEF in cycle 1.
  - M1 signals stay 0.
- M0 and M1 both request every cycle for 6 cycles (RR build):
  - grant order M0, M1, M0, M1, M0, M1.
  - Fixed-priority build: M0 every cycle, M1_GNT never asserted.
- M1 writes 0x5A5A5A5A to 0x20, then M0 reads 0x20 in the next cycle: M0_RDATA=0x5A5A5A5A with M0_RVALID one cycle after its grant.
- Locked sequence with M0 and M1 both requesting:
  - M0 reads 0x30 with LOCK=1.
  - M0 idles 2 cycles while M1_REQ=1: M1_GNT stays 0.
  - M0 writes 0x30 with LOCK=0: granted.
  - M1 is granted in the following cycle.
- Assert RST in the cycle after an M1 read grant:
  - M1_RVALID never pulses, lock_own=NONE.
  - After deassert, M0 wins the first contention.
- Idle cycles with no REQ: MWEN=0, MADDR=0; SRAM contents are unchanged when checked by a later read-back.
